// File: rtl/if_prefetch_if.sv
// Fetch-side bundle: ROM request/response plus the valid/ready hand-off to ID.
// The master modport is the prefetcher's view, the slave modport is the environment's.
interface if_prefetch_if #(
  parameter int unsigned PTR_W = 2
);
  logic              flush;
  logic [31:0]       new_pc;
  logic              rom_ce;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_inst;
  logic              id_ready;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic [PTR_W:0]    fifo_count;

  modport master (
    input  flush, new_pc, rom_inst, id_ready,
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, fifo_count
  );

  modport slave (
    output flush, new_pc, rom_inst, id_ready,
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, fifo_count
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetcher: fetches sequential words from a combinational ROM into a
// small FIFO and presents the head to ID; a redirect flushes the FIFO and reloads
// the PC. Head outputs are zeroed whenever the FIFO is empty.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  if_prefetch_if.master        bus
);

  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [31:0]      ALIGN_MSK = 32'hFFFF_FFFC;

  logic [31:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  logic              head_valid_c;
  logic              pop_c;
  logic              push_c;

  // A pop is only honoured when no redirect is pending; a flush discards the head.
  assign head_valid_c = (count_q != '0);
  assign pop_c        = head_valid_c & bus.id_ready & ~bus.flush;
  // Fetch whenever a slot is free now or is being freed by this cycle's pop.
  assign push_c       = rst & ~bus.flush & ((count_q < FULL) | pop_c);

  // Next-state for PC, pointers and occupancy; flush overrides everything else.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      pc_d     = bus.new_pc & ALIGN_MSK;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC & ALIGN_MSK;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only ever observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= bus.rom_inst;
    end
  end

  assign bus.rom_ce     = push_c;
  assign bus.rom_addr   = pc_q & ALIGN_MSK;
  assign bus.id_valid   = head_valid_c;
  assign bus.id_pc      = head_valid_c ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign bus.id_inst    = head_valid_c ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a queue-based reference model of the FIFO and PC is advanced
// every clock edge and compared against the DUT's combinational outputs mid-cycle.
module tb_if_prefetch;

  localparam int unsigned PTR_W = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef logic [100:0] snap_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_hi;

  if_prefetch_if #(.PTR_W(PTR_W)) bus ();
  if_prefetch_if #(.PTR_W(PTR_W)) bus_hi ();

  if_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut_hi (
    .clk (clk),
    .rst (rst_hi),
    .bus (bus_hi)
  );

  always #5 clk = ~clk;

  // ROM contents: fixed words at 0..C, an address hash elsewhere.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      32'hC:   return 32'h0000_0044;
      default: return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
    endcase
  endfunction

  assign bus.rom_inst    = bus.rom_ce    ? rom_f(bus.rom_addr)    : 32'hFFFF_FFFF;
  assign bus_hi.rom_inst = bus_hi.rom_ce ? rom_f(bus_hi.rom_addr) : 32'hFFFF_FFFF;

  entry_t      q[$];
  logic [31:0] mpc;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic snap_t dut_snap();
    return {bus.rom_ce, bus.rom_addr, bus.id_valid, bus.id_pc, bus.id_inst, bus.fifo_count};
  endfunction

  function automatic logic model_pop();
    return rst && !bus.flush && (q.size() != 0) && bus.id_ready;
  endfunction

  function automatic logic model_ce();
    return rst && !bus.flush && ((q.size() < DEPTH) || model_pop());
  endfunction

  function automatic snap_t model_snap();
    entry_t h;
    h = (q.size() != 0) ? q[0] : '0;
    return {model_ce(), mpc, (q.size() != 0), h.pc, h.inst, 3'(q.size())};
  endfunction

  // Advance one clock: decide pop/fetch from pre-edge state, then update the model.
  task automatic cycle();
    logic pop;
    logic ce;
    pop = model_pop();
    ce  = model_ce();
    @(posedge clk);
    if (!rst) begin
      q.delete();
      mpc = 32'h0;
    end else if (bus.flush) begin
      q.delete();
      mpc = bus.new_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(q.pop_front());
      if (ce) begin
        q.push_back({mpc, rom_f(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.new_pc   = 32'h0;
    bus.id_ready = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    snap_t obs, exp;
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.new_pc   = 32'h0;
    bus.id_ready = 1'b1;
    #1;
    q.delete();
    mpc = 32'h0;
    obs = dut_snap(); exp = model_snap(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, exp); end
    cycle();
    obs = dut_snap(); exp = model_snap(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_stream();
    snap_t obs, exp;
    logic [31:0] ref_inst [4];
    ref_inst = '{32'h11, 32'h22, 32'h33, 32'h44};
    apply_reset();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      obs = dut_snap(); exp = model_snap(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL stream[%0d] got=%h exp=%h", i, obs, exp); end
      if (i < 4) begin
        n_tests++;
        if (bus.rom_addr !== 32'(4 * i)) begin
          n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, bus.rom_addr, 32'(4 * i));
        end
      end
      if (i >= 1 && i <= 4) begin
        n_tests++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * (i - 1)) || bus.id_inst !== ref_inst[i - 1]) begin
          n_fail++;
          $display("FAIL stream_head[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                   i, bus.id_valid, bus.id_pc, bus.id_inst, 32'(4 * (i - 1)), ref_inst[i - 1]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    snap_t obs, exp;
    apply_reset();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      obs = dut_snap(); exp = model_snap(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL bp_fill[%0d] got=%h exp=%h", i, obs, exp); end
      cycle();
    end
    n_tests++;
    if (bus.fifo_count !== 3'd4 || bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_full got cnt=%0d ce=%b addr=%h exp cnt=4 ce=0 addr=10",
               bus.fifo_count, bus.rom_ce, bus.rom_addr);
    end
    bus.id_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h10) begin
      n_fail++; $display("FAIL bp_release got ce=%b addr=%h exp ce=1 addr=10", bus.rom_ce, bus.rom_addr);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      obs = dut_snap(); exp = model_snap(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL bp_stream[%0d] got=%h exp=%h", i, obs, exp); end
      n_tests++;
      if (bus.fifo_count !== 3'd4) begin
        n_fail++; $display("FAIL bp_count[%0d] got=%0d exp=4", i, bus.fifo_count);
      end
      cycle();
    end
  endtask

  task automatic test_flush();
    snap_t obs, exp;
    apply_reset();
    bus.id_ready = 1'b0;
    bus.flush    = 1'b1;
    bus.new_pc   = 32'h20;
    cycle();
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      obs = dut_snap(); exp = model_snap(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL flush_fill[%0d] got=%h exp=%h", i, obs, exp); end
      cycle();
    end
    n_tests++;
    if (bus.id_pc !== 32'h20 || bus.fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL flush_pre got pc=%h cnt=%0d exp pc=20 cnt=4", bus.id_pc, bus.fifo_count);
    end
    bus.flush  = 1'b1;
    bus.new_pc = 32'h0000_0103;
    #1;
    obs = dut_snap(); exp = model_snap(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL flush_req got=%h exp=%h", obs, exp); end
    cycle();
    bus.flush = 1'b0;
    #1;
    n_tests++;
    if (bus.id_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rom_addr !== 32'h100 || bus.rom_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after got v=%b cnt=%0d addr=%h ce=%b exp v=0 cnt=0 addr=100 ce=1",
               bus.id_valid, bus.fifo_count, bus.rom_addr, bus.rom_ce);
    end
    cycle();
    n_tests++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_inst !== rom_f(32'h100)) begin
      n_fail++;
      $display("FAIL flush_target got v=%b pc=%h inst=%h exp v=1 pc=100 inst=%h",
               bus.id_valid, bus.id_pc, bus.id_inst, rom_f(32'h100));
    end
  endtask

  task automatic test_flush_pop();
    snap_t obs, exp;
    bus.id_ready = 1'b1;
    bus.flush    = 1'b1;
    bus.new_pc   = 32'h200;
    #1;
    n_tests++;
    if (bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL flushpop_edge got ce=%b v=%b exp ce=0 v=1", bus.rom_ce, bus.id_valid);
    end
    cycle();
    bus.flush = 1'b0;
    #1;
    n_tests++;
    if (bus.id_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rom_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL flushpop_after got v=%b cnt=%0d addr=%h exp v=0 cnt=0 addr=200",
               bus.id_valid, bus.fifo_count, bus.rom_addr);
    end
    cycle();
    bus.flush  = 1'b1;
    bus.new_pc = 32'h300;
    cycle();
    bus.new_pc = 32'h406;
    cycle();
    bus.flush = 1'b0;
    #1;
    n_tests++;
    if (bus.rom_addr !== 32'h404 || bus.fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL flush_last got addr=%h cnt=%0d exp addr=404 cnt=0", bus.rom_addr, bus.fifo_count);
    end
    obs = dut_snap(); exp = model_snap(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL flush_last_snap got=%h exp=%h", obs, exp); end
    cycle();
  endtask

  task automatic test_async_reset();
    snap_t obs, exp;
    apply_reset();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    n_tests++;
    if (bus.fifo_count !== 3'd3 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got cnt=%0d v=%b exp cnt=3 v=1", bus.fifo_count, bus.id_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    mpc = 32'h0;
    obs = dut_snap(); exp = model_snap(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL arst_now got=%h exp=%h", obs, exp); end
    cycle();
    rst          = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0) begin
      n_fail++; $display("FAIL arst_resume got ce=%b addr=%h exp ce=1 addr=0", bus.rom_ce, bus.rom_addr);
    end
    cycle();
    n_tests++;
    if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h11) begin
      n_fail++; $display("FAIL arst_first got pc=%h inst=%h exp pc=0 inst=11", bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic test_random();
    snap_t obs, exp;
    for (int i = 0; i < 300; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 19) == 0);
      bus.new_pc   = $urandom;
      #1;
      obs = dut_snap(); exp = model_snap(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL random[%0d] got=%h exp=%h", i, obs, exp); end
      cycle();
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] ref_pc [4];
    ref_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_hi = 1'b1;
    #1;
    n_tests++;
    if (bus_hi.id_valid !== 1'b0 || bus_hi.rom_addr !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL wrap_start got v=%b addr=%h exp v=0 addr=fffffff8", bus_hi.id_valid, bus_hi.rom_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (bus_hi.id_valid !== 1'b1 || bus_hi.id_pc !== ref_pc[k] || bus_hi.id_inst !== rom_f(ref_pc[k])) begin
        n_fail++;
        $display("FAIL wrap[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 k, bus_hi.id_valid, bus_hi.id_pc, bus_hi.id_inst, ref_pc[k], rom_f(ref_pc[k]));
      end
    end
  endtask

  initial begin
    rst              = 1'b0;
    rst_hi           = 1'b0;
    bus.flush        = 1'b0;
    bus.new_pc       = 32'h0;
    bus.id_ready     = 1'b0;
    bus_hi.flush     = 1'b0;
    bus_hi.new_pc    = 32'h0;
    bus_hi.id_ready  = 1'b1;
    mpc              = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_pop();
    test_async_reset();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
